sprite_motion_scheduler: RTL
============================

// Module: sprite_motion_scheduler
// PURPOSE
//  Owns the X/Y positions of N_SPRITES game objects (player + monsters). Once per frame,
//  at a fixed vertical-blank line, it walks every sprite through one shared next-position
//  ALU, one sprite per cycle, so positions never change while lines are being drawn.
//  Sits between the button/AI request logic and the per-sprite pixel-fill/rgb mux.
// PARAMETERS
//  N_SPRITES  4    number of sprites managed
//  IDX_W      2    clog2(N_SPRITES)
//  STEP       2    horizontal pixels moved per frame
//  VSTEP      8    vertical pixels moved per frame on move_down
//  X_MIN      150  left wrap bound (hCount units)
//  X_MAX      800  right wrap bound
//  Y_MIN      35   top wrap bound (vCount units)
//  Y_MAX      515  bottom wrap bound
//  X_INIT     450  reset x of sprite 0; sprite i resets to X_INIT + i*X_SPACING
//  X_SPACING  40   reset x pitch between sprites
//  Y_INIT     250  reset y of every sprite
//  TRIG_LINE  516  vCount line that starts the per-frame update
// PORTS
//  clk         in   1           pixel-domain clock
//  rst         in   1           reset, asynchronous, active-low (asserted when 0)
//  hCount      in   10          horizontal counter from the display controller
//  vCount      in   10          vertical counter from the display controller
//  sprite_en   in   N_SPRITES   1 = sprite i is live and may move
//  move_left   in   N_SPRITES   per-sprite left request
//  move_right  in   N_SPRITES   per-sprite right request
//  move_down   in   N_SPRITES   per-sprite down request
//  load        in   1           one-cycle pulse: overwrite one sprite's position
//  load_idx    in   IDX_W       target sprite for load
//  load_x      in   10          x value for load
//  load_y      in   10          y value for load
//  x_pos       out  10*N_SPRITES  sprite i x at bits [10*i+9:10*i]
//  y_pos       out  10*N_SPRITES  sprite i y at same slicing
//  busy        out  1           high in LATCH/UPDATE/DONE
//  frame_done  out  1           one-cycle pulse when all sprites are updated
//  overrun     out  1           sticky: a trigger arrived while busy
// BEHAVIOUR
//  Reset: x_i = X_INIT + i*X_SPACING, y_i = Y_INIT, FSM=IDLE, busy=0, frame_done=0, overrun=0.
//  Trigger: registered (vCount==TRIG_LINE && hCount==0); one pulse per frame.
//  FSM: IDLE -trigger-> LATCH (snapshot sprite_en/move_* into regs, idx=0) -> UPDATE
//   (one sprite per cycle, idx++; after idx==N_SPRITES-1 -> DONE) -> DONE (frame_done=1)
//   -> IDLE. Latency trigger->frame_done = N_SPRITES+2 cycles. Requests changing after
//   LATCH do not affect the current frame.
//  Per-sprite update, using the snapshot:
//   disabled sprite, or left&right both set: x held.
//   right only: x+STEP > X_MAX -> x=X_MIN, else x+=STEP.
//   left only:  x < X_MIN+STEP -> x=X_MAX, else x-=STEP.
//   down: y+VSTEP > Y_MAX -> y=Y_MIN, else y+=VSTEP; independent of left/right.
//   Compare in 11 bits so the sum never overflows.
//  load: writes x/y of load_idx in the same cycle, in any state. If it hits the sprite
//   UPDATE is writing that cycle, load wins; that sprite is not re-updated this frame.
//  Trigger while busy: ignored, overrun set until reset.
//  Reset mid-update: abort at once to the reset values; no frame_done pulse.
// STRUCTURE
//  Shared header vga_consts.vh: screen bounds, TRIG_LINE, FSM state encodings
//   (IDLE/LATCH/UPDATE/DONE, 2 bits).
//  Sub-module sprite_pos_alu: combinational; x, y, en, l, r, d -> next x, next y with wrap.
//  Top: FSM, idx counter, snapshot regs, position register array, load mux.
// TESTING
//  1 Reset low, then release -> x_pos = {570,530,490,450}, y_pos all 250, busy=0, overrun=0.
//  2 move_right[0]=1, one frame -> x0 452, frame_done exactly N_SPRITES+2 cycles after trigger.
//  3 load idx0 x=800, move_right[0], frame -> x0=150; load x=151, move_left -> x0=800.
//  4 move_down[2], load y=510 -> y2=35 after frame; sprite_en[2]=0 -> x2/y2 unchanged.
//  5 load on idx1 in the cycle UPDATE writes idx1 -> load value kept; frame_done still pulses.
//  6 Force trigger while busy -> overrun=1 and stays 1; reset mid-UPDATE -> reset values, no frame_done.

Source files
------------

// File: rtl/sprite_motion_scheduler_pkg.sv
// Shared constants, FSM encoding and reset-position helper for the sprite motion scheduler.
package sprite_motion_scheduler_pkg;

    localparam int N_SPRITES = 4;
    localparam int IDX_W     = 2;
    localparam int STEP      = 2;
    localparam int VSTEP     = 8;
    localparam int X_MIN     = 150;
    localparam int X_MAX     = 800;
    localparam int Y_MIN     = 35;
    localparam int Y_MAX     = 515;
    localparam int X_INIT    = 450;
    localparam int X_SPACING = 40;
    localparam int Y_INIT    = 250;

    localparam logic [9:0]       TRIG_LINE = 10'd516;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SPRITES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic [9:0] init_x(input int i);
        return 10'(X_INIT + i * X_SPACING);
    endfunction

endpackage

// File: rtl/sprite_motion_scheduler_alu.sv
// Combinational next-position for one sprite: step left/right/down with wrap at screen bounds.
// Zero latency; no flow control.
module sprite_pos_alu
    import sprite_motion_scheduler_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       en,
    input  logic       l,
    input  logic       r,
    input  logic       d,
    output logic [9:0] next_x,
    output logic [9:0] next_y
);

    // 11-bit compares keep x+STEP / y+VSTEP from wrapping past 1023.
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] VSTEP_W = 11'(VSTEP);
    localparam logic [10:0] X_MIN_W = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);

    logic [10:0] x_ext;
    logic [10:0] y_ext;

    always_comb begin
        x_ext  = {1'b0, x};
        y_ext  = {1'b0, y};
        next_x = x;
        next_y = y;
        if (en) begin
            if (r && !l) begin
                if (x_ext + STEP_W > X_MAX_W) next_x = 10'(X_MIN);
                else                          next_x = x + 10'(STEP);
            end else if (l && !r) begin
                if (x_ext < X_MIN_W + STEP_W) next_x = 10'(X_MAX);
                else                          next_x = x - 10'(STEP);
            end
            if (d) begin
                if (y_ext + VSTEP_W > Y_MAX_W) next_y = 10'(Y_MIN);
                else                           next_y = y + 10'(VSTEP);
            end
        end
    end

endmodule

// File: rtl/sprite_motion_scheduler.sv
// Per-frame sprite position updater: at TRIG_LINE walks sprites through one shared ALU.
// Trigger->frame_done N_SPRITES+2 cycles; no backpressure, a trigger while busy sets overrun.
module sprite_motion_scheduler
    import sprite_motion_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               hCount,
    input  logic [9:0]               vCount,
    input  logic [N_SPRITES-1:0]     sprite_en,
    input  logic [N_SPRITES-1:0]     move_left,
    input  logic [N_SPRITES-1:0]     move_right,
    input  logic [N_SPRITES-1:0]     move_down,
    input  logic                     load,
    input  logic [IDX_W-1:0]         load_idx,
    input  logic [9:0]               load_x,
    input  logic [9:0]               load_y,
    output logic [10*N_SPRITES-1:0]  x_pos,
    output logic [10*N_SPRITES-1:0]  y_pos,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   trig_q;
    logic [IDX_W-1:0]       idx;
    logic [N_SPRITES-1:0]   snap_en;
    logic [N_SPRITES-1:0]   snap_l;
    logic [N_SPRITES-1:0]   snap_r;
    logic [N_SPRITES-1:0]   snap_d;
    logic [9:0]             pos_x [N_SPRITES];
    logic [9:0]             pos_y [N_SPRITES];
    logic [9:0]             alu_x;
    logic [9:0]             alu_y;

    sprite_pos_alu u_alu (
        .x      (pos_x[idx]),
        .y      (pos_y[idx]),
        .en     (snap_en[idx]),
        .l      (snap_l[idx]),
        .r      (snap_r[idx]),
        .d      (snap_d[idx]),
        .next_x (alu_x),
        .next_y (alu_y)
    );

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE:   if (trig_q) state_nxt = S_LATCH;
            S_LATCH:  begin busy = 1'b1; state_nxt = S_UPDATE; end
            S_UPDATE: begin
                busy = 1'b1;
                if (idx == LAST_IDX) state_nxt = S_DONE;
            end
            S_DONE:   begin busy = 1'b1; frame_done = 1'b1; state_nxt = S_IDLE; end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            trig_q  <= 1'b0;
            idx     <= '0;
            snap_en <= '0;
            snap_l  <= '0;
            snap_r  <= '0;
            snap_d  <= '0;
            overrun <= 1'b0;
        end else begin
            state  <= state_nxt;
            trig_q <= (vCount == TRIG_LINE) && (hCount == 10'd0);
            if (state == S_LATCH) begin
                idx     <= '0;
                snap_en <= sprite_en;
                snap_l  <= move_left;
                snap_r  <= move_right;
                snap_d  <= move_down;
            end else if (state == S_UPDATE) begin
                idx <= idx + 1'b1;
            end
            if (trig_q && state != S_IDLE) overrun <= 1'b1;
        end
    end

    // load is written after the ALU result so it wins on a same-sprite collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                pos_x[i] <= init_x(i);
                pos_y[i] <= 10'(Y_INIT);
            end
        end else begin
            if (state == S_UPDATE) begin
                pos_x[idx] <= alu_x;
                pos_y[idx] <= alu_y;
            end
            if (load) begin
                pos_x[load_idx] <= load_x;
                pos_y[load_idx] <= load_y;
            end
        end
    end

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_out
        assign x_pos[10*g +: 10] = pos_x[g];
        assign y_pos[10*g +: 10] = pos_y[g];
    end

endmodule
